// File: rtl/psdi_pkg.sv
// Shared psdi_dsp types for the coefficient RAM path.
package psdi_pkg;

  localparam int COEF_ADDR_W = 7;
  localparam int COEF_DATA_W = 8;

  typedef enum logic {
    OWN_L = 1'b0,
    OWN_R = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } tag_t;

  function automatic owner_t peer(owner_t o);
    return (o == OWN_L) ? OWN_R : OWN_L;
  endfunction

endpackage

// File: rtl/coef_ram_arbiter_if.sv
// Filter-side request/response bus plus the RAM port pair.
interface coef_ram_arbiter_if
  import psdi_pkg::*;
#(
  parameter int ADDR_W = COEF_ADDR_W,
  parameter int DATA_W = COEF_DATA_W
) ();

  logic              req0;
  logic              lock0;
  logic [ADDR_W-1:0] addr0;
  logic              gnt0;
  logic              rvalid0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              lock1;
  logic [ADDR_W-1:0] addr1;
  logic              gnt1;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata1;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dataout;

  modport master (
    output req0, lock0, addr0,
    output req1, lock1, addr1,
    output ram_dataout,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  ram_addr
  );

  modport slave (
    input  req0, lock0, addr0,
    input  req1, lock1, addr1,
    input  ram_dataout,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output ram_addr
  );

endinterface

// File: rtl/coef_ram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with burst lock and starvation guard.
import psdi_pkg::*;

module rr_arb2 #(
  parameter int MAX_LOCK = 64
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   req0,
  input  logic   lock0,
  input  logic   req1,
  input  logic   lock1,
  output logic   gnt0,
  output logic   gnt1,
  output owner_t owner
);

  localparam int CW = 8;

  owner_t        last_q, last_d;
  logic          held_q, held_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          keep;
  logic          any;
  logic          lk;
  logic          other;

  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= OWN_R;
      held_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      last_q <= last_d;
      held_q <= held_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    owner  = last_q;
    last_d = last_q;
    held_d = 1'b0;
    cnt_d  = '0;
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    lk     = 1'b0;
    other  = 1'b0;
    any    = !reset && (req0 || req1);
    keep   = held_q
          && ((last_q == OWN_L) ? req0 : req1)
          && (cnt_q < CW'(MAX_LOCK));

    unique case ({req1, req0})
      2'b11:   owner = keep ? last_q : peer(last_q);
      2'b01:   owner = OWN_L;
      2'b10:   owner = OWN_R;
      default: owner = last_q;
    endcase

    if (any) begin
      gnt0   = (owner == OWN_L);
      gnt1   = (owner == OWN_R);
      lk     = (owner == OWN_L) ? lock0 : lock1;
      other  = (owner == OWN_L) ? req1 : req0;
      last_d = owner;
      held_d = lk;
      // a fresh owner starts its burst count at one
      if (lk && other) begin
        cnt_d = ((owner == last_q) ? cnt_q : CW'(0)) + CW'(1);
      end
    end
  end

endmodule

// File: rtl/coef_ram_arbiter.sv
// Shares the coefficient RAM between the left and right lowpass filters.
import psdi_pkg::*;

module coef_ram_arbiter #(
  parameter int ADDR_W   = COEF_ADDR_W,
  parameter int DATA_W   = COEF_DATA_W,
  parameter int RAM_LAT  = 1,
  parameter int MAX_LOCK = 64
) (
  input logic               clock,
  input logic               reset,
  coef_ram_arbiter_if.slave bus
);

  logic              gnt0;
  logic              gnt1;
  owner_t            owner;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] coef;
  tag_t [RAM_LAT:0]  tags_q;
  tag_t              tag_in;

  rr_arb2 #(
    .MAX_LOCK (MAX_LOCK)
  ) u_arb (
    .clock (clock),
    .reset (reset),
    .req0  (bus.req0),
    .lock0 (bus.lock0),
    .req1  (bus.req1),
    .lock1 (bus.lock1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .owner (owner)
  );

  assign tag_in.valid = gnt0 || gnt1;
  assign tag_in.owner = owner;

  // the tag trails the address by RAM_LAT so it lines up with the data
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q <= '0;
      tags_q <= '0;
    end else begin
      if (tag_in.valid) begin
        addr_q <= (owner == OWN_L) ? bus.addr0 : bus.addr1;
      end
      tags_q[0] <= tag_in;
      for (int k = 1; k <= RAM_LAT; k++) begin
        tags_q[k] <= tags_q[k-1];
      end
    end
  end

  assign coef         = bus.ram_dataout;
  assign bus.gnt0     = gnt0;
  assign bus.gnt1     = gnt1;
  assign bus.ram_addr = addr_q;
  assign bus.rdata0   = coef;
  assign bus.rdata1   = coef;
  assign bus.rvalid0  = tags_q[RAM_LAT].valid
                     && (tags_q[RAM_LAT].owner == OWN_L);
  assign bus.rvalid1  = tags_q[RAM_LAT].valid
                     && (tags_q[RAM_LAT].owner == OWN_R);

endmodule

// File: tb/tb_coef_ram_arbiter.sv
// Bench: two arbiters (RAM_LAT 1/MAX_LOCK 4 and RAM_LAT 3/MAX_LOCK 64) on shared stimulus.
module tb_coef_ram_arbiter;

  localparam int AW = 7;
  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req0  = 1'b0;
  logic          lock0 = 1'b0;
  logic          req1  = 1'b0;
  logic          lock1 = 1'b0;
  logic [AW-1:0] addr0 = '0;
  logic [AW-1:0] addr1 = '0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit armed  = 1'b0;

  always #5 clock = ~clock;

  coef_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
  coef_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

  assign bus_a.req0  = req0;
  assign bus_a.lock0 = lock0;
  assign bus_a.addr0 = addr0;
  assign bus_a.req1  = req1;
  assign bus_a.lock1 = lock1;
  assign bus_a.addr1 = addr1;
  assign bus_b.req0  = req0;
  assign bus_b.lock0 = lock0;
  assign bus_b.addr0 = addr0;
  assign bus_b.req1  = req1;
  assign bus_b.lock1 = lock1;
  assign bus_b.addr1 = addr1;

  coef_ram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RAM_LAT(1), .MAX_LOCK(4)
  ) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a)
  );

  coef_ram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RAM_LAT(3), .MAX_LOCK(64)
  ) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b)
  );

  function automatic logic [DW-1:0] coef(input logic [AW-1:0] a);
    return {1'b0, a} + 8'h40;
  endfunction

  // synchronous-read RAM models with latency 1 and 3
  logic [DW-1:0] pa;
  logic [DW-1:0] pb [3];
  always @(posedge clock) begin
    pa    <= coef(bus_a.ram_addr);
    pb[0] <= coef(bus_b.ram_addr);
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign bus_a.ram_dataout = pa;
  assign bus_b.ram_dataout = pb[2];

  // reference model: who owns the RAM, and which reads come back when
  typedef struct {
    int            d;
    int            due;
    int            own;
    logic [AW-1:0] adr;
  } rd_t;

  rd_t           pend [$];
  int            m_last [2];
  bit            m_held [2];
  int            m_run  [2];
  logic [AW-1:0] m_raddr [2];

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic int max_of(input int d);
    return (d == 0) ? 4 : 64;
  endfunction

  function automatic int exp_gnt(input int d);
    if (reset) return -1;
    if (req0 && req1) begin
      if (m_held[d] && m_run[d] < max_of(d)) return m_last[d];
      return 1 - m_last[d];
    end
    if (req0) return 0;
    if (req1) return 1;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_dut(input int d);
    logic          g0, g1, v0, v1;
    logic [AW-1:0] ra;
    logic [DW-1:0] r0, r1;
    int            eg;
    bit            hit;
    int            own;
    logic [AW-1:0] adr;
    string         s;
    if (d == 0) begin
      g0 = bus_a.gnt0; g1 = bus_a.gnt1; ra = bus_a.ram_addr;
      v0 = bus_a.rvalid0; v1 = bus_a.rvalid1;
      r0 = bus_a.rdata0; r1 = bus_a.rdata1;
    end else begin
      g0 = bus_b.gnt0; g1 = bus_b.gnt1; ra = bus_b.ram_addr;
      v0 = bus_b.rvalid0; v1 = bus_b.rvalid1;
      r0 = bus_b.rdata0; r1 = bus_b.rdata1;
    end
    s   = (d == 0) ? "A" : "B";
    eg  = exp_gnt(d);
    hit = 1'b0;
    own = 0;
    adr = '0;
    foreach (pend[i]) begin
      if (pend[i].d == d && pend[i].due == cyc) begin
        hit = 1'b1;
        own = pend[i].own;
        adr = pend[i].adr;
      end
    end
    chk($sformatf("%s gnt0 @%0d", s, cyc), g0, eg == 0);
    chk($sformatf("%s gnt1 @%0d", s, cyc), g1, eg == 1);
    chk($sformatf("%s ram_addr @%0d", s, cyc), ra, m_raddr[d]);
    chk($sformatf("%s rvalid0 @%0d", s, cyc), v0, hit && own == 0);
    chk($sformatf("%s rvalid1 @%0d", s, cyc), v1, hit && own == 1);
    if (hit) begin
      chk($sformatf("%s rdata @%0d", s, cyc), (own == 0) ? r0 : r1,
          coef(adr));
    end
  endtask

  task automatic update_model(input int d);
    int g;
    bit lk;
    bit oth;
    rd_t e;
    if (reset) begin
      m_last[d]  = 1;
      m_held[d]  = 1'b0;
      m_run[d]   = 0;
      m_raddr[d] = '0;
      for (int i = pend.size() - 1; i >= 0; i--)
        if (pend[i].d == d) pend.delete(i);
      return;
    end
    for (int i = pend.size() - 1; i >= 0; i--)
      if (pend[i].d == d && pend[i].due <= cyc) pend.delete(i);
    g = exp_gnt(d);
    if (g < 0) begin
      m_held[d] = 1'b0;
      m_run[d]  = 0;
      return;
    end
    lk  = (g == 0) ? lock0 : lock1;
    oth = (g == 0) ? req1 : req0;
    if (lk && oth) m_run[d] = ((g == m_last[d]) ? m_run[d] : 0) + 1;
    else m_run[d] = 0;
    m_held[d]  = lk;
    m_last[d]  = g;
    m_raddr[d] = (g == 0) ? addr0 : addr1;
    e.d   = d;
    e.due = cyc + 1 + lat_of(d);
    e.own = g;
    e.adr = m_raddr[d];
    pend.push_back(e);
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (armed) begin
        check_dut(0);
        check_dut(1);
      end
      update_model(0);
      update_model(1);
      if (reset) armed = 1'b1;
      cyc++;
    end
  end

  task automatic step(input bit rs, input bit q0, input bit l0, input int a0,
                      input bit q1, input bit l1, input int a1);
    @(posedge clock);
    #1;
    reset = rs;
    req0  = q0;
    lock0 = l0;
    addr0 = AW'(a0);
    req1  = q1;
    lock1 = l1;
    addr1 = AW'(a1);
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [11:0] pat;
    pat = 12'b1101_1110_1111;

    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0);
    idle(1);
    chk("rst A ram_addr", bus_a.ram_addr, 0);
    chk("rst A rvalid0", bus_a.rvalid0, 0);
    chk("rst A rvalid1", bus_a.rvalid1, 0);
    chk("rst B ram_addr", bus_b.ram_addr, 0);
    chk("rst B rvalid1", bus_b.rvalid1, 0);

    step(0, 1, 0, 5, 0, 0, 0);
    chk("t1 A gnt0", bus_a.gnt0, 1);
    chk("t1 A gnt1", bus_a.gnt1, 0);
    idle(1);
    chk("t1 A ram_addr", bus_a.ram_addr, 5);
    idle(1);
    chk("t1 A rvalid0", bus_a.rvalid0, 1);
    chk("t1 A rdata0", bus_a.rdata0, 8'h45);
    chk("t1 A rvalid1", bus_a.rvalid1, 0);
    idle(2);

    step(0, 1, 0, 127, 0, 0, 0);
    idle(4);

    step(0, 0, 0, 0, 1, 0, 7);
    chk("t6 B gnt1", bus_b.gnt1, 1);
    idle(1);
    chk("t6 B ram_addr", bus_b.ram_addr, 7);
    idle(2);
    chk("t6 B rvalid1 early", bus_b.rvalid1, 0);
    idle(1);
    chk("t6 B rvalid1", bus_b.rvalid1, 1);
    chk("t6 B rdata1", bus_b.rdata1, 8'h47);
    idle(1);

    step(0, 1, 0, 10, 1, 0, 20);
    chk("t2 A gnt0 t", bus_a.gnt0, 1);
    step(0, 1, 0, 10, 1, 0, 20);
    chk("t2 A gnt1 t+1", bus_a.gnt1, 1);
    chk("t2 A ram_addr t+1", bus_a.ram_addr, 10);
    step(0, 1, 0, 10, 1, 0, 20);
    chk("t2 A gnt0 t+2", bus_a.gnt0, 1);
    chk("t2 A ram_addr t+2", bus_a.ram_addr, 20);
    chk("t2 A rvalid0", bus_a.rvalid0, 1);
    chk("t2 A rdata0", bus_a.rdata0, 8'h4A);
    idle(1);
    chk("t2 A ram_addr t+3", bus_a.ram_addr, 10);
    chk("t2 A rvalid1", bus_a.rvalid1, 1);
    chk("t2 A rdata1", bus_a.rdata1, 8'h54);
    idle(3);

    step(0, 0, 0, 0, 1, 0, 33);
    chk("t5 A gnt1", bus_a.gnt1, 1);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("t5 A ram_addr pre", bus_a.ram_addr, 33);
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 1, i, 1, 0, 50);
      if (i == 0) begin
        chk("t5 A rvalid1 flushed", bus_a.rvalid1, 0);
        chk("t5 A ram_addr cleared", bus_a.ram_addr, 0);
      end
      chk($sformatf("t4 A gnt0 #%0d", i), bus_a.gnt0, pat[i]);
      chk($sformatf("t4 B gnt0 #%0d", i), bus_b.gnt0, 1);
    end
    idle(5);

    step(1, 0, 0, 0, 0, 0, 0);
    for (int j = 0; j < 14; j++) begin
      if (j < 10) step(0, 1, 1, j, 1, 0, 99);
      else if (j == 10) step(0, 0, 0, 0, 1, 0, 99);
      else idle(1);
      if (j < 10) chk($sformatf("t3 B gnt0 #%0d", j), bus_b.gnt0, 1);
      if (j == 10) chk("t3 B gnt1", bus_b.gnt1, 1);
      if (j >= 4) begin
        chk($sformatf("t3 B rvalid0 #%0d", j), bus_b.rvalid0, 1);
        chk($sformatf("t3 B rdata0 #%0d", j), bus_b.rdata0, 8'h40 + j - 4);
      end
    end

    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 127),
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 127));
    end
    idle(8);
    chk("drain pending", pend.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
